// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU/load requesters, the write arbiter and the register-file write port.
// Handshake: a request transfers on a cycle where valid and ready are both high; valid/rd/data hold until then.
interface regfile_write_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_wsel;
  logic [XLEN-1:0]   rf_wdata;
  logic              init_busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rf_wen, rf_wsel, rf_wdata, init_busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rf_wen, rf_wsel, rf_wdata, init_busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback, clearing x1..x31 after reset.
// Optional macro RF_ARB_BYPASS_EN adds two read-bypass ports exposing the write in flight.
module regfile_write_arbiter #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  regfile_write_arbiter_if.slave bus,
`ifdef RF_ARB_BYPASS_EN
  input  logic [ADDR_W-1:0]   byp_rsel1,
  input  logic [ADDR_W-1:0]   byp_rsel2,
  output logic                byp_hit1,
  output logic                byp_hit2,
  output logic [XLEN-1:0]     byp_data1,
  output logic [XLEN-1:0]     byp_data2,
`endif
  output logic                dbg_state_o
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              rr_last_q, rr_last_d;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_wsel_q, rf_wsel_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  logic alu_ready, mem_ready;
  logic alu_xfer, mem_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      clr_idx_q  <= ADDR_W'(1);
      rr_last_q  <= SRC_MEM;
      rf_wen_q   <= 1'b0;
      rf_wsel_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      rr_last_q  <= rr_last_d;
      rf_wen_q   <= rf_wen_d;
      rf_wsel_q  <= rf_wsel_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign alu_xfer = bus.alu_valid & alu_ready;
  assign mem_xfer = bus.mem_valid & mem_ready;

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    rr_last_d  = rr_last_q;
    rf_wen_d   = 1'b0;
    rf_wsel_d  = rf_wsel_q;
    rf_wdata_d = rf_wdata_q;
    case (state_q)
      S_INIT: begin
        rf_wen_d   = 1'b1;
        rf_wsel_d  = clr_idx_q;
        rf_wdata_d = '0;
        clr_idx_d  = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == {ADDR_W{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        // x0 requests still consume their turn but never raise the write enable.
        if (alu_xfer) begin
          rr_last_d  = SRC_ALU;
          rf_wsel_d  = bus.alu_rd;
          rf_wdata_d = bus.alu_data;
          rf_wen_d   = (bus.alu_rd != '0);
        end else if (mem_xfer) begin
          rr_last_d  = SRC_MEM;
          rf_wsel_d  = bus.mem_rd;
          rf_wdata_d = bus.mem_data;
          rf_wen_d   = (bus.mem_rd != '0);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    alu_ready     = 1'b0;
    mem_ready     = 1'b0;
    bus.init_busy = rst | (state_q == S_INIT);
    if (!rst && state_q == S_RUN) begin
      alu_ready = bus.alu_valid & (!bus.mem_valid | (rr_last_q == SRC_MEM));
      mem_ready = bus.mem_valid & (!bus.alu_valid | (rr_last_q == SRC_ALU));
    end
    bus.alu_ready = alu_ready;
    bus.mem_ready = mem_ready;
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_wsel  = rf_wsel_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign dbg_state_o  = state_q;

`ifdef RF_ARB_BYPASS_EN
  assign byp_hit1  = rf_wen_q & (rf_wsel_q == byp_rsel1) & (byp_rsel1 != '0);
  assign byp_hit2  = rf_wen_q & (rf_wsel_q == byp_rsel2) & (byp_rsel2 != '0);
  assign byp_data1 = rf_wdata_q;
  assign byp_data2 = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset clear, round-robin grants, x0 handling and mid-run reset.
module tb_regfile_write_arbiter;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst;
  logic dbg_state;
  int   n_checks;
  int   n_fail;

  regfile_write_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) wb_if ();

`ifdef RF_ARB_BYPASS_EN
  logic [ADDR_W-1:0] byp_rsel1, byp_rsel2;
  logic              byp_hit1, byp_hit2;
  logic [XLEN-1:0]   byp_data1, byp_data2;
`endif

  regfile_write_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (wb_if.slave),
`ifdef RF_ARB_BYPASS_EN
    .byp_rsel1   (byp_rsel1),
    .byp_rsel2   (byp_rsel2),
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic v, input logic [ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    wb_if.alu_valid = v;
    wb_if.alu_rd    = rd;
    wb_if.alu_data  = d;
  endtask

  task automatic set_mem(input logic v, input logic [ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    wb_if.mem_valid = v;
    wb_if.mem_rd    = rd;
    wb_if.mem_data  = d;
  endtask

  task automatic check_wr(input string tag, input logic wen, input logic [ADDR_W-1:0] wsel,
                          input logic [XLEN-1:0] wdata);
    check({tag, "_wen"},   32'(wb_if.rf_wen),   32'(wen));
    check({tag, "_wsel"},  32'(wb_if.rf_wsel),  32'(wsel));
    check({tag, "_wdata"}, 32'(wb_if.rf_wdata), 32'(wdata));
  endtask

  task automatic check_rdy(input string tag, input logic ar, input logic mr);
    check({tag, "_alu_ready"}, 32'(wb_if.alu_ready), 32'(ar));
    check({tag, "_mem_ready"}, 32'(wb_if.mem_ready), 32'(mr));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_alu(1'b1, 5'd4, 32'h0);
    set_mem(1'b1, 5'd6, 32'h0);
`ifdef RF_ARB_BYPASS_EN
    byp_rsel1 = '0;
    byp_rsel2 = '0;
`endif

    // reset held two cycles with both requesters asking
    tick();
    tick();
    check_wr("reset", 1'b0, 5'd0, 32'h0);
    check_rdy("reset", 1'b0, 1'b0);
    check("reset_init_busy", 32'(wb_if.init_busy), 32'd1);
    check("reset_state", 32'(dbg_state), 32'd0);

    // clear sequence x1..x31
    rst = 1'b0;
    #1;
    check("init_busy_after_rst", 32'(wb_if.init_busy), 32'd1);
    for (int i = 1; i <= 31; i++) begin
      tick();
      check_wr($sformatf("clr%0d", i), 1'b1, ADDR_W'(i), 32'h0);
      if (i < 31) begin
        check_rdy($sformatf("clr%0d", i), 1'b0, 1'b0);
        check($sformatf("clr%0d_busy", i), 32'(wb_if.init_busy), 32'd1);
      end else begin
        check("clr_done_busy", 32'(wb_if.init_busy), 32'd0);
        check("clr_done_state", 32'(dbg_state), 32'd1);
      end
      if (i == 30) begin
        set_alu(1'b0, 5'd0, 32'h0);
        set_mem(1'b0, 5'd0, 32'h0);
      end
    end

    // single ALU writeback
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check_rdy("alu_only", 1'b1, 1'b0);
    tick();
    check_wr("alu_only", 1'b1, 5'd5, 32'hDEADBEEF);

    // single load writeback leaves MEM as last winner
    set_alu(1'b0, 5'd0, 32'h0);
    set_mem(1'b1, 5'd2, 32'h55);
    #1;
    check_rdy("mem_only", 1'b0, 1'b1);
    tick();
    check_wr("mem_only", 1'b1, 5'd2, 32'h55);

    // both requesting: ALU, MEM, ALU, MEM
    set_alu(1'b1, 5'd3, 32'h11);
    set_mem(1'b1, 5'd7, 32'h22);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_rdy($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
      tick();
      if ((k % 2) == 0) check_wr($sformatf("rr%0d", k), 1'b1, 5'd3, 32'h11);
      else              check_wr($sformatf("rr%0d", k), 1'b1, 5'd7, 32'h22);
    end

    // idle cycle: enable drops, index/data hold
    set_alu(1'b0, 5'd0, 32'h0);
    set_mem(1'b0, 5'd0, 32'h0);
    tick();
    check_wr("idle", 1'b0, 5'd7, 32'h22);

    // load to x0 is accepted but never writes
    set_mem(1'b1, 5'd0, 32'h1234);
    #1;
    check_rdy("x0", 1'b0, 1'b1);
    tick();
    check_wr("x0", 1'b0, 5'd0, 32'h1234);

    // x0 consumed MEM's turn, so ALU wins next
    set_alu(1'b1, 5'd4, 32'h44);
    set_mem(1'b1, 5'd6, 32'h66);
    #1;
    check_rdy("after_x0", 1'b1, 1'b0);
    tick();
    check_wr("after_x0", 1'b1, 5'd4, 32'h44);

    // reset during an ALU transfer to x9
    set_mem(1'b0, 5'd0, 32'h0);
    set_alu(1'b1, 5'd9, 32'h99);
    #1;
    check_rdy("pre_rst", 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_rdy("mid_rst", 1'b0, 1'b0);
    check("mid_rst_busy", 32'(wb_if.init_busy), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check_wr("post_rst", 1'b0, 5'd0, 32'h0);
    check_rdy("post_rst", 1'b0, 1'b0);
    check("post_rst_busy", 32'(wb_if.init_busy), 32'd1);
    tick();
    check_wr("reclr1", 1'b1, 5'd1, 32'h0);
    tick();
    check_wr("reclr2", 1'b1, 5'd2, 32'h0);

    // let the clear finish with the ALU request still pending
    set_alu(1'b1, 5'd9, 32'hA5A5A5A5);
    for (int i = 3; i <= 31; i++) begin
      tick();
      if (i < 31) check_rdy($sformatf("reclr%0d", i), 1'b0, 1'b0);
    end
    check_wr("reclr31", 1'b1, 5'd31, 32'h0);
    check_rdy("pending_alu", 1'b1, 1'b0);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    check_wr("pending_alu", 1'b1, 5'd9, 32'hA5A5A5A5);

`ifdef RF_ARB_BYPASS_EN
    byp_rsel1 = 5'd9;
    byp_rsel2 = 5'd0;
    #1;
    check("byp_hit1", 32'(byp_hit1), 32'd1);
    check("byp_data1", byp_data1, 32'hA5A5A5A5);
    check("byp_hit2", 32'(byp_hit2), 32'd0);
    byp_rsel2 = 5'd8;
    #1;
    check("byp_hit2_miss", 32'(byp_hit2), 32'd0);
    tick();
    check("byp_hit1_idle", 32'(byp_hit1), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
